// File: rtl/maze_pkg.sv
// Shared cell codes, FSM states and grid geometry for the maze store.
// Optional feature macro: MAZE_VISIT_COUNT_EN (visited-cell counter).
package maze_pkg;

  localparam int MAZE_WIDTH = 6;
  localparam int CELL_WIDTH = 2;

  localparam logic [1:0] CELL_FREE    = 2'd0;
  localparam logic [1:0] CELL_WALL    = 2'd1;
  localparam logic [1:0] CELL_VISITED = 2'd2;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SERVE,
    ST_DUMP,
    ST_FINISHED
  } state_t;

endpackage

// File: rtl/maze_raster_counter.sv
// Row-major {row,col} raster counter shared by the load and dump scans.
// Optional feature macro: MAZE_VISIT_COUNT_EN (not used in this file).
module maze_raster_counter
  import maze_pkg::*;
#(
  parameter int maze_width = MAZE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  inc,
  output logic [maze_width-1:0] row,
  output logic [maze_width-1:0] col,
  output logic                  last
);

  logic [2*maze_width-1:0] idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + 1'b1;
    end
  end

  assign row  = idx[2*maze_width-1:maze_width];
  assign col  = idx[maze_width-1:0];
  assign last = &idx;

endmodule

// File: rtl/maze_store.sv
// Maze grid store: raster load, solver read/mark service, visited dump.
// Optional feature macro: MAZE_VISIT_COUNT_EN (enables visit_count).
module maze_store
  import maze_pkg::*;
#(
  parameter int maze_width = MAZE_WIDTH,
  parameter int cell_width = CELL_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  input  logic                    load_bit,
  output logic                    load_ready,
  output logic                    maze_ready,
  input  logic [maze_width-1:0]   row,
  input  logic [maze_width-1:0]   col,
  input  logic                    maze_oe,
  input  logic                    maze_we,
  output logic                    maze_in,
  input  logic                    done,
  output logic                    dump_valid,
  input  logic                    dump_ready,
  output logic [maze_width-1:0]   dump_row,
  output logic [maze_width-1:0]   dump_col,
  output logic                    dump_done,
  output logic [2*maze_width:0]   visit_count
);

  localparam int AW    = 2 * maze_width;
  localparam int CELLS = 1 << AW;

  localparam logic [cell_width-1:0] C_FREE =
    cell_width'(CELL_FREE);
  localparam logic [cell_width-1:0] C_WALL =
    cell_width'(CELL_WALL);
  localparam logic [cell_width-1:0] C_VIS =
    cell_width'(CELL_VISITED);

  logic [cell_width-1:0] grid [CELLS];

  state_t state;

  logic                  cnt_clear;
  logic                  cnt_inc;
  logic                  cnt_last;
  logic [maze_width-1:0] cnt_row;
  logic [maze_width-1:0] cnt_col;
  logic [AW-1:0]         cnt_addr;
  logic [AW-1:0]         srv_addr;
  logic [cell_width-1:0] cnt_cell;
  logic [cell_width-1:0] srv_cell;

  logic                  beat;
  logic                  mark;
  logic                  dump_step;

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [cell_width-1:0] wr_data;

  assign cnt_addr = {cnt_row, cnt_col};
  assign srv_addr = {row, col};
  assign cnt_cell = grid[cnt_addr];
  assign srv_cell = grid[srv_addr];

  assign beat = (state == ST_LOAD) && load_valid && load_ready;
  // Only FREE cells change on a mark: walls drop it, VISITED is a no-op.
  assign mark = (state == ST_SERVE) && maze_we && (srv_cell == C_FREE);

  assign dump_step = (state == ST_DUMP) &&
                     (dump_valid ? dump_ready : (cnt_cell != C_VIS));

  assign cnt_clear = (state == ST_SERVE) && done;
  assign cnt_inc   = beat || dump_step;

  maze_raster_counter #(
    .maze_width(maze_width)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(cnt_clear),
    .inc  (cnt_inc),
    .row  (cnt_row),
    .col  (cnt_col),
    .last (cnt_last)
  );

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cnt_addr;
    wr_data = {{(cell_width-1){1'b0}}, load_bit};
    unique case (1'b1)
      beat: begin
        wr_en = 1'b1;
      end
      mark: begin
        wr_en   = 1'b1;
        wr_addr = srv_addr;
        wr_data = C_VIS;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      grid[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      load_ready <= 1'b1;
      maze_ready <= 1'b0;
      maze_in    <= 1'b0;
      dump_valid <= 1'b0;
      dump_row   <= '0;
      dump_col   <= '0;
      dump_done  <= 1'b0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          if (beat && cnt_last) begin
            state      <= ST_SERVE;
            load_ready <= 1'b0;
            maze_ready <= 1'b1;
          end
        end
        ST_SERVE: begin
          if (maze_oe) begin
            maze_in <= (srv_cell == C_WALL);
          end
          if (done) begin
            state <= ST_DUMP;
          end
        end
        ST_DUMP: begin
          if (!dump_valid && cnt_cell == C_VIS) begin
            dump_valid <= 1'b1;
            dump_row   <= cnt_row;
            dump_col   <= cnt_col;
          end else if (dump_valid && dump_ready) begin
            dump_valid <= 1'b0;
          end
          if (dump_step && cnt_last) begin
            state     <= ST_FINISHED;
            dump_done <= 1'b1;
          end
        end
        ST_FINISHED: ;
        default: state <= ST_LOAD;
      endcase
    end
  end

`ifdef MAZE_VISIT_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      visit_count <= '0;
    end else if (mark) begin
      visit_count <= visit_count + 1'b1;
    end
  end
`else
  assign visit_count = '0;
`endif

endmodule

// File: tb/tb_maze_store.sv
// Randomized scoreboard bench for maze_store with a cell-array model.
// Honors MAZE_VISIT_COUNT_EN for the expected visit_count.
module tb_maze_store;

  localparam int N     = 64;
  localparam int CELLS = N * N;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_bit = 1'b0;
  logic        load_ready;
  logic        maze_ready;
  logic [5:0]  row = '0;
  logic [5:0]  col = '0;
  logic        maze_oe = 1'b0;
  logic        maze_we = 1'b0;
  logic        maze_in;
  logic        done = 1'b0;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [5:0]  dump_row;
  logic [5:0]  dump_col;
  logic        dump_done;
  logic [12:0] visit_count;

  maze_store dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_bit   (load_bit),
    .load_ready (load_ready),
    .maze_ready (maze_ready),
    .row        (row),
    .col        (col),
    .maze_oe    (maze_oe),
    .maze_we    (maze_we),
    .maze_in    (maze_in),
    .done       (done),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_row   (dump_row),
    .dump_col   (dump_col),
    .dump_done  (dump_done),
    .visit_count(visit_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model codes: 0 free, 1 wall, 2 visited
  int   model [CELLS];
  int   model_vc = 0;
  int   exp_vc = 0;
  bit   serving = 0;
  bit   dumping = 0;
  bit   rd_pend = 0;
  bit   held = 0;
  logic [5:0] h_row, h_col;
  bit   rd_q [$];
  int   dump_q [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) rd_pend <= maze_oe && serving;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) chk("rd_queue_empty", 1, 0);
      else chk("maze_in", maze_in, rd_q.pop_front());
    end
    if (rst_n) chk("visit_count", visit_count, exp_vc);
    if (dumping) begin
      if (held) begin
        chk("hold_valid", dump_valid, 1);
        chk("hold_row", dump_row, h_row);
        chk("hold_col", dump_col, h_col);
      end
      held  = dump_valid && !dump_ready;
      h_row = dump_row;
      h_col = dump_col;
      if (dump_valid && dump_ready) begin
        if (dump_q.size() == 0) begin
          chk("dump_queue_empty", 1, 0);
        end else begin
          int e;
          e = dump_q.pop_front();
          chk("dump_row", dump_row, e / N);
          chk("dump_col", dump_col, e % N);
        end
      end
    end else begin
      held = 0;
    end
  end

  function automatic int wall_for(input int idx);
    int r, c;
    r = idx / N;
    c = idx % N;
    if (r == 5 && c == 7) return 1;
    if (r == 5 && c == 8) return 0;
    if (r == 3 && (c == 3 || c == 4)) return 0;
    if (r == 20 && c == 20) return 0;
    return ($urandom_range(0, 3) == 0) ? 1 : 0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    load_valid = 0;
    maze_oe = 0;
    maze_we = 0;
    done = 0;
    dump_ready = 0;
    serving = 0;
    dumping = 0;
    step();
    chk("rst_load_ready", load_ready, 1);
    chk("rst_maze_ready", maze_ready, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dump_done", dump_done, 0);
    chk("rst_maze_in", maze_in, 0);
    chk("rst_visit_count", visit_count, 0);
    rd_q.delete();
    dump_q.delete();
    model_vc = 0;
    exp_vc = 0;
    rst_n = 1'b1;
  endtask

  task automatic load_maze(input bit rnd, input int stop_at);
    int idx = 0;
    int b;
    while (idx < CELLS && idx != stop_at) begin
      load_valid = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
      b = rnd ? wall_for(idx) : 0;
      load_bit = b[0];
      maze_oe = $urandom_range(0, 1);
      maze_we = $urandom_range(0, 1);
      done = $urandom_range(0, 1);
      row = $urandom;
      col = $urandom;
      if (load_valid && idx == CELLS - 1)
        chk("ready_before_last", maze_ready, 0);
      step();
      if (load_valid) begin
        model[idx] = b;
        idx++;
      end
    end
    load_valid = 0;
    maze_oe = 0;
    maze_we = 0;
    done = 0;
    if (idx == CELLS) begin
      chk("maze_ready_after_load", maze_ready, 1);
      chk("load_ready_after_load", load_ready, 0);
      serving = 1;
    end
  endtask

  task automatic op(input bit oe, input bit we, input bit dn,
                    input int r, input int c);
    int a;
    a = r * N + c;
    maze_oe = oe;
    maze_we = we;
    done = dn;
    row = r[5:0];
    col = c[5:0];
    if (oe) rd_q.push_back(model[a] == 1);
    if (we && model[a] == 0) begin
      model[a] = 2;
      model_vc++;
    end
    if (dn)
      for (int i = 0; i < CELLS; i++)
        if (model[i] == 2) dump_q.push_back(i);
    step();
`ifdef MAZE_VISIT_COUNT_EN
    exp_vc = model_vc;
`else
    exp_vc = 0;
`endif
    maze_oe = 0;
    maze_we = 0;
    done = 0;
    if (dn) begin
      serving = 0;
      dumping = 1;
    end
  endtask

  task automatic run_dump();
    int hold = 0;
    int n = 0;
    while (!dump_done && n < 30000) begin
      if (hold < 10 && (dump_valid || hold > 0)) begin
        dump_ready = 0;
        hold++;
      end else begin
        dump_ready = $urandom_range(0, 1);
      end
      step();
      n++;
    end
    chk("dump_done_reached", dump_done, 1);
    dump_ready = 0;
    step();
    dumping = 0;
    chk("dump_left", dump_q.size(), 0);
    chk("fin_dump_valid", dump_valid, 0);
    chk("fin_maze_ready", maze_ready, 1);
    chk("fin_load_ready", load_ready, 0);
    chk("fin_dump_done", dump_done, 1);
  endtask

  initial begin
    int n;
    do_reset();
    load_maze(1, 100);
    do_reset();
    load_maze(1, -1);

    op(1, 0, 0, 5, 7);
    op(1, 0, 0, 5, 8);
    op(0, 1, 0, 5, 7);
    op(1, 0, 0, 5, 7);
    op(0, 1, 0, 3, 3);
    op(0, 1, 0, 3, 4);
    op(0, 1, 0, 3, 3);
    op(1, 1, 0, 3, 3);
    repeat (400)
      op($urandom_range(0, 1), $urandom_range(0, 1), 0,
         $urandom_range(0, 15), $urandom_range(0, 15));
    op(1, 1, 1, 20, 20);
    run_dump();

    do_reset();
    load_maze(0, -1);
    op(1, 1, 0, 0, 2);
    op(0, 1, 0, 62, 1);
    op(0, 0, 1, 0, 0);
    dump_ready = 0;
    n = 0;
    while (!dump_valid && n < 50) begin
      step();
      n++;
    end
    chk("mid_dump_valid", dump_valid, 1);
    chk("mid_dump_row", dump_row, 0);
    chk("mid_dump_col", dump_col, 2);
    repeat (3) step();
    do_reset();
    chk("post_rst_dump_valid", dump_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
